// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: IF/IE registers, priority resolve and CPU dispatch handshake.
// Define INTC_EDGE_DETECT_EN for rising-edge request capture (default: level).
module interrupt_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        rd,
    input  logic        wr,
    input  logic [4:0]  int_req,
    output logic [4:0]  int_ack,
    output logic        int_pending,
    input  logic        int_dispatch,
    output logic [7:0]  int_vector,
    output logic        int_vector_valid
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q;
    logic [4:0] if_q, if_d;
    logic [7:0] ie_q, ie_d;
    logic [7:0] vec_q, vec_d;
    logic [4:0] ack_q, ack_d;
    logic       valid_q;
    logic [4:0] set, masked, win, dclr, swclr, base;
    logic [7:0] win_vec;
    logic       sel_if, sel_ie, wr_if, wr_ie, take;
    logic       unused_rd;

    // Reads have no side effects, so the strobe is not needed.
    assign unused_rd = rd;

    assign sel_if = (a == 16'hFF0F);
    assign sel_ie = (a == 16'hFFFF);
    assign wr_if  = wr & sel_if;
    assign wr_ie  = wr & sel_ie;

`ifdef INTC_EDGE_DETECT_EN
    logic [4:0] req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= int_req;
        end
    end

    assign set = int_req & ~req_q;
`else
    assign set = int_req;
`endif

    assign masked      = ie_q[4:0] & if_q;
    assign int_pending = |masked;

    always_comb begin
        win     = '0;
        win_vec = 8'h00;
        for (int i = 4; i >= 0; i--) begin
            if (masked[i]) begin
                win     = 5'(1 << i);
                win_vec = 8'h40 + 8'(i * 8);
            end
        end
    end

    assign take  = (state_q == IDLE) & int_dispatch;
    assign dclr  = take ? win : 5'b0;
    assign swclr = wr_if ? (if_q & ~din[4:0] & int_req) : 5'b0;

    // A new request edge overrides both a CPU write and a dispatch clear.
    assign base  = wr_if ? din[4:0] : if_q;
    assign if_d  = (base & ~dclr) | set;
    assign ie_d  = wr_ie ? din : ie_q;
    assign vec_d = take ? win_vec : vec_q;
    assign ack_d = dclr | swclr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            if_q    <= '0;
            ie_q    <= '0;
            vec_q   <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if_q  <= if_d;
            ie_q  <= ie_d;
            vec_q <= vec_d;
            ack_q <= ack_d;
            unique case (state_q)
                IDLE: begin
                    if (int_dispatch) begin
                        state_q <= BUSY;
                        valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!int_dispatch) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dout = 8'hFF;
        if (sel_if) begin
            dout = {3'b111, if_q};
        end else if (sel_ie) begin
            dout = ie_q;
        end
    end

    assign int_ack          = ack_q;
    assign int_vector       = vec_q;
    assign int_vector_valid = valid_q;
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: directed and random stimulus against a per-cycle
// reference model; expected outputs are queued and checked by a monitor.
module tb_interrupt_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  int_req = '0;
    logic [4:0]  int_ack;
    logic        int_pending;
    logic        int_dispatch = 1'b0;
    logic [7:0]  int_vector;
    logic        int_vector_valid;

    interrupt_ctrl dut (
        .clk(clk), .rst_n(rst_n), .a(a), .din(din), .dout(dout),
        .rd(rd), .wr(wr), .int_req(int_req), .int_ack(int_ack),
        .int_pending(int_pending), .int_dispatch(int_dispatch),
        .int_vector(int_vector), .int_vector_valid(int_vector_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ack;
        logic [7:0] vec;
        logic       valid;
        logic       pend;
        logic [7:0] dout;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    bit [4:0] m_if;
    bit [7:0] m_ie;
    bit [4:0] m_req;
    bit       m_busy;
    bit [7:0] m_vec;

    function automatic void chk(string n, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
        end
    endfunction

    // Apply one cycle of inputs and predict the state after the next edge.
    task automatic step(input bit r, input logic [15:0] aa, input logic [7:0] dd,
                        input bit w, input logic [4:0] rq, input bit dsp);
        exp_t e;
        bit [4:0] nif, ack;
        int winner;
        @(negedge clk);
        rst_n = r; a = aa; din = dd; wr = w; rd = ~w;
        int_req = rq; int_dispatch = dsp;
        ack = '0;
        if (!r) begin
            m_if = '0; m_ie = '0; m_req = '0; m_busy = 0; m_vec = '0;
        end else begin
            nif = (w && aa == 16'hFF0F) ? dd[4:0] : m_if;
            for (int i = 0; i < 5; i++)
                if (w && aa == 16'hFF0F && m_if[i] && !dd[i] && rq[i]) ack[i] = 1;
            if (!m_busy && dsp) begin
                winner = -1;
                for (int i = 0; i < 5; i++)
                    if (m_ie[i] && m_if[i]) begin winner = i; break; end
                m_vec = (winner < 0) ? 8'h00 : 8'(64 + 8 * winner);
                if (winner >= 0) begin nif[winner] = 0; ack[winner] = 1; end
                m_busy = 1;
            end else if (m_busy && !dsp) begin
                m_busy = 0;
            end
            for (int i = 0; i < 5; i++) begin
`ifdef INTC_EDGE_DETECT_EN
                if (rq[i] && !m_req[i]) nif[i] = 1;
`else
                if (rq[i]) nif[i] = 1;
`endif
            end
            m_if = nif;
            if (w && aa == 16'hFFFF) m_ie = dd;
            m_req = rq;
        end
        e.ack = ack;
        e.vec = m_vec;
        e.valid = m_busy;
        e.pend = |(m_ie[4:0] & m_if);
        e.dout = (aa == 16'hFF0F) ? {3'b111, m_if} :
                 (aa == 16'hFFFF) ? m_ie : 8'hFF;
        q.push_back(e);
    endtask

    task automatic post_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ack", {3'b0, int_ack}, {3'b0, e.ack});
                chk("vector", int_vector, e.vec);
                chk("valid", {7'b0, int_vector_valid}, {7'b0, e.valid});
                chk("pending", {7'b0, int_pending}, {7'b0, e.pend});
                chk("dout", dout, e.dout);
            end
        end
    end

    initial begin : stim
        logic [4:0]  rq;
        logic [15:0] aa;
        bit          dsp, r, w;
        int          s;
        rq = '0;
        dsp = 0;
        step(0, 16'hFF0F, 8'h00, 0, 5'h00, 0);
        // Reset taken while BUSY
        step(1, 16'hFFFF, 8'h01, 1, 5'h00, 0);
        step(1, 16'hFF0F, 8'h01, 1, 5'h00, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 1);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 1);
        step(0, 16'hFF0F, 8'h00, 0, 5'h00, 1);
        post_edge();
        chk("rst_if", dout, 8'hE0);
        chk("rst_valid", {7'b0, int_vector_valid}, 8'h00);
        chk("rst_ack", {3'b0, int_ack}, 8'h00);
        step(1, 16'hFFFF, 8'h00, 0, 5'h00, 0);
        post_edge();
        chk("rst_ie", dout, 8'h00);
        // Timer path
        step(1, 16'hFFFF, 8'h04, 1, 5'h00, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h04, 0);
        post_edge();
        chk("tim_if", dout, 8'hE4);
        chk("tim_pend", {7'b0, int_pending}, 8'h01);
        step(1, 16'hFF0F, 8'h00, 0, 5'h04, 1);
        post_edge();
        chk("tim_vec", int_vector, 8'h50);
        chk("tim_valid", {7'b0, int_vector_valid}, 8'h01);
        chk("tim_ack", {3'b0, int_ack}, 8'h04);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 0);
        post_edge();
        chk("tim_ack_drop", {3'b0, int_ack}, 8'h00);
        // Priority
        step(1, 16'hFF0F, 8'h1F, 1, 5'h00, 0);
        step(1, 16'hFFFF, 8'h1A, 1, 5'h00, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 1);
        post_edge();
        chk("pri_vec1", int_vector, 8'h48);
        chk("pri_if1", dout, 8'hFD);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 1);
        post_edge();
        chk("pri_vec2", int_vector, 8'h58);
        chk("pri_if2", dout, 8'hF5);
        // Cancelled dispatch
        step(1, 16'hFFFF, 8'h00, 1, 5'h00, 0);
        step(1, 16'hFF0F, 8'h01, 1, 5'h00, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 1);
        post_edge();
        chk("cxl_vec", int_vector, 8'h00);
        chk("cxl_ack", {3'b0, int_ack}, 8'h00);
        chk("cxl_if", dout, 8'hE1);
        // Collision and software clear
        step(1, 16'hFF0F, 8'h00, 1, 5'h01, 0);
        post_edge();
        chk("col_if", dout, 8'hE1);
        step(1, 16'hFF0F, 8'h00, 1, 5'h00, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h04, 0);
        step(1, 16'hFF0F, 8'h00, 1, 5'h04, 0);
        post_edge();
        chk("sw_ack", {3'b0, int_ack}, 8'h04);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 0);
        post_edge();
        chk("sw_ack_drop", {3'b0, int_ack}, 8'h00);
        // Held request, then a clearing write
        step(1, 16'hFF0F, 8'h00, 1, 5'h08, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h08, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h08, 0);
        step(1, 16'hFF0F, 8'h00, 1, 5'h08, 0);
        step(1, 16'hFF0F, 8'h00, 0, 5'h00, 0);
        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 199) != 0);
            s = $urandom_range(0, 3);
            aa = (s == 0) ? 16'hFF0F : (s == 1) ? 16'hFFFF :
                 (s == 2) ? 16'($urandom) : 16'hFF0E;
            w = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 5) == 0) rq[i] = ~rq[i];
            if ($urandom_range(0, 3) == 0) dsp = ~dsp;
            step(r, aa, 8'($urandom), w, rq, dsp);
        end
        repeat (5) begin
            if (q.size() != 0) post_edge();
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
